inst_mem_loader: RTL and testbench

Parametrised instruction memory for the single-cycle CPU, replacing file-initialised ROM with a run-time load port. A handshaked stream writes the program sequentially from address 0 and records its length. The fetch port then serves registered reads. Fetches at or beyond the program length return a configurable fill instruction and raise a past-end flag, so the machine never sees undefined words after its last instruction.

---
 rtl/inst_mem_loader.sv | 157 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Run-time loadable instruction memory for the single-cycle CPU. A handshaked
// stream writes the program sequentially from address 0 and records its length.
// Once the program is resident the fetch port serves registered reads. Fetches
// at or beyond the program length return FILL_INST and raise PastEnd, so the
// core never executes undefined words that follow its last instruction.
//
// Parameters:
//   IW        instruction width in bits
//   AW        address width, depth is 2**AW words
//   FILL_INST word returned for past-end fetches (halt encoding)
//
// Ports:
//   Clk          in   1     single clock, rising edge
//   Reset        in   1     asynchronous, active-high; clears control state
//   LoadStart    in   1     pulse, begins (or restarts) a program load
//   LoadValid    in   1     LoadData/LoadLast valid
//   LoadData     in   IW    instruction word to write
//   LoadLast     in   1     final word of the program
//   LoadReady    out  1     a load beat is accepted this cycle
//   Loaded       out  1     program resident, fetch enabled
//   ProgLen      out  AW+1  number of words in the loaded program
//   FetchEn      in   1     fetch request for InstAddress
//   InstAddress  in   AW    fetch address
//   InstOut      out  IW    fetched instruction (registered)
//   InstValid    out  1     InstOut updated by a fetch accepted last cycle
//   PastEnd      out  1     last fetch address was >= ProgLen
// -----------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int              IW        = 9,
  parameter int              AW        = 11,
  parameter logic [IW-1:0]   FILL_INST = {IW{1'b1}}
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           LoadStart,
  input  logic           LoadValid,
  input  logic [IW-1:0]  LoadData,
  input  logic           LoadLast,
  output logic           LoadReady,
  output logic           Loaded,
  output logic [AW:0]    ProgLen,
  input  logic           FetchEn,
  input  logic [AW-1:0]  InstAddress,
  output logic [IW-1:0]  InstOut,
  output logic           InstValid,
  output logic           PastEnd
);

  localparam int            DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   ptr_r;
  logic [IW-1:0]   mem_r [DEPTH];

  logic            wr_en_s;
  logic            done_s;
  logic [AW:0]     next_len_s;
  logic            fetch_s;
  logic            in_range_s;

  // Load/fetch qualifiers derived from the current state and inputs.
  always_comb begin
    // A restart in the same cycle as a beat discards that beat.
    wr_en_s    = (state_r == LOAD) && LoadValid && !LoadStart;
    // The load ends on the LoadLast beat or when the last address is written,
    // so the pointer never wraps back onto word 0.
    done_s     = wr_en_s && (LoadLast || (ptr_r == LAST_ADDR));
    // Length is formed at AW+1 bits so a full memory reports 2**AW.
    next_len_s = {1'b0, ptr_r} + {{AW{1'b0}}, 1'b1};
    fetch_s    = (state_r == READY) && FetchEn;
    // Unsigned compare at AW+1 bits against the recorded length.
    in_range_s = ({1'b0, InstAddress} < ProgLen);
  end

  // Program storage write port; contents intentionally survive reset.
  always_ff @(posedge Clk) begin
    if (wr_en_s) begin
      mem_r[ptr_r] <= LoadData;
    end
  end

  // Load controller: state, write pointer, length and load-side outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= IDLE;
      ptr_r     <= {AW{1'b0}};
      ProgLen   <= {(AW+1){1'b0}};
      LoadReady <= 1'b0;
      Loaded    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (LoadStart) begin
            state_r   <= LOAD;
            ptr_r     <= {AW{1'b0}};
            LoadReady <= 1'b1;
          end
        end
        LOAD: begin
          if (LoadStart) begin
            // Restart: rewind only; the previous length stays visible.
            ptr_r <= {AW{1'b0}};
          end else if (done_s) begin
            state_r   <= READY;
            ProgLen   <= next_len_s;
            ptr_r     <= {AW{1'b0}};
            LoadReady <= 1'b0;
            Loaded    <= 1'b1;
          end else if (wr_en_s) begin
            ptr_r <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        READY: begin
          if (LoadStart) begin
            // ProgLen holds until the new load completes.
            state_r   <= LOAD;
            ptr_r     <= {AW{1'b0}};
            LoadReady <= 1'b1;
            Loaded    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          ptr_r     <= {AW{1'b0}};
          LoadReady <= 1'b0;
          Loaded    <= 1'b0;
        end
      endcase
    end
  end

  // Registered fetch port; InstOut and PastEnd hold when no fetch is taken.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      InstOut   <= {IW{1'b0}};
      InstValid <= 1'b0;
      PastEnd   <= 1'b0;
    end else begin
      InstValid <= fetch_s;
      if (fetch_s) begin
        PastEnd <= !in_range_s;
        InstOut <= in_range_s ? mem_r[InstAddress] : FILL_INST;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  localparam logic [8:0] FILL = 9'h1FF;

  logic        Clk = 1'b0;
  logic        Reset;

  // Default-parameter instance (IW=9, AW=11)
  logic        LoadStart, LoadValid, LoadLast, LoadReady, Loaded;
  logic [8:0]  LoadData;
  logic [11:0] ProgLen;
  logic        FetchEn;
  logic [10:0] InstAddress;
  logic [8:0]  InstOut;
  logic        InstValid, PastEnd;

  // Small instance (AW=3) for the full-memory boundary
  logic        s_start, s_valid, s_last, s_ready, s_loaded;
  logic [8:0]  s_data;
  logic [3:0]  s_len;
  logic        s_fetch;
  logic [2:0]  s_addr;
  logic [8:0]  s_inst;
  logic        s_ivalid, s_past;

  int total = 0;
  int bad   = 0;

  // Reference model: program as a list of words plus load/resident flags
  bit         m_loading, m_loaded;
  int         m_len;
  logic [8:0] m_q[$];
  logic [8:0] m_prog [2048];
  logic [8:0] m_inst;
  bit         m_past, m_valid;

  inst_mem_loader dut (
    .Clk(Clk), .Reset(Reset), .LoadStart(LoadStart), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(LoadReady),
    .Loaded(Loaded), .ProgLen(ProgLen), .FetchEn(FetchEn),
    .InstAddress(InstAddress), .InstOut(InstOut), .InstValid(InstValid),
    .PastEnd(PastEnd)
  );

  inst_mem_loader #(.IW(9), .AW(3), .FILL_INST(9'h1FF)) dut_small (
    .Clk(Clk), .Reset(Reset), .LoadStart(s_start), .LoadValid(s_valid),
    .LoadData(s_data), .LoadLast(s_last), .LoadReady(s_ready),
    .Loaded(s_loaded), .ProgLen(s_len), .FetchEn(s_fetch),
    .InstAddress(s_addr), .InstOut(s_inst), .InstValid(s_ivalid),
    .PastEnd(s_past)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_loading = 1'b0;
    m_loaded  = 1'b0;
    m_len     = 0;
    m_inst    = 9'h000;
    m_past    = 1'b0;
    m_valid   = 1'b0;
    m_q.delete();
  endtask

  task automatic check_outs();
    check_eq("LoadReady", {31'd0, LoadReady}, {31'd0, m_loading});
    check_eq("Loaded",    {31'd0, Loaded},    {31'd0, m_loaded});
    check_eq("ProgLen",   {20'd0, ProgLen},   m_len);
    check_eq("InstValid", {31'd0, InstValid}, {31'd0, m_valid});
    check_eq("InstOut",   {23'd0, InstOut},   {23'd0, m_inst});
    check_eq("PastEnd",   {31'd0, PastEnd},   {31'd0, m_past});
  endtask

  // One clock of main-instance stimulus; model predicts the post-edge outputs.
  task automatic cyc(input bit st, input bit v, input logic [8:0] d, input bit l,
                     input bit fe, input logic [10:0] a);
    LoadStart = st; LoadValid = v; LoadData = d; LoadLast = l;
    FetchEn = fe; InstAddress = a;
    m_valid = fe && m_loaded;
    if (m_valid) begin
      m_past = (int'(a) >= m_len);
      m_inst = m_past ? FILL : m_prog[a];
    end
    if (m_loading) begin
      if (st) begin
        m_q.delete();
      end else if (v) begin
        m_q.push_back(d);
        if (l || m_q.size() == 2048) begin
          foreach (m_q[i]) m_prog[i] = m_q[i];
          m_len     = m_q.size();
          m_loading = 1'b0;
          m_loaded  = 1'b1;
        end
      end
    end else if (st) begin
      m_loading = 1'b1;
      m_loaded  = 1'b0;
      m_q.delete();
    end
    @(posedge Clk); #1;
    check_outs();
  endtask

  initial begin
    logic [8:0]  rd;
    logic [10:0] ra;
    Reset = 1'b1;
    LoadStart = 1'b0; LoadValid = 1'b0; LoadData = 9'h000; LoadLast = 1'b0;
    FetchEn = 1'b0; InstAddress = 11'd0;
    s_start = 1'b0; s_valid = 1'b0; s_data = 9'h000; s_last = 1'b0;
    s_fetch = 1'b0; s_addr = 3'd0;
    m_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_outs();
    Reset = 1'b0;

    // Fetch before any load is blocked
    cyc(0, 0, 9'h000, 0, 1, 11'd0);

    // Basic 3-word load and in-range fetches
    cyc(1, 0, 9'h000, 0, 0, 11'd0);
    cyc(0, 1, 9'h031, 0, 0, 11'd0);
    cyc(0, 1, 9'h102, 0, 0, 11'd0);
    cyc(0, 1, 9'h033, 1, 0, 11'd0);
    check_eq("len3", {20'd0, ProgLen}, 32'd3);
    check_eq("loaded3", {31'd0, Loaded}, 32'd1);
    cyc(0, 0, 9'h000, 0, 1, 11'd0);
    check_eq("f0", {23'd0, InstOut}, 32'h031);
    cyc(0, 0, 9'h000, 0, 1, 11'd1);
    check_eq("f1", {23'd0, InstOut}, 32'h102);
    cyc(0, 0, 9'h000, 0, 1, 11'd2);
    check_eq("f2", {23'd0, InstOut}, 32'h033);
    check_eq("f2past", {31'd0, PastEnd}, 32'd0);
    // Past-end fetches
    cyc(0, 0, 9'h000, 0, 1, 11'd3);
    check_eq("f3", {23'd0, InstOut}, 32'h1FF);
    check_eq("f3past", {31'd0, PastEnd}, 32'd1);
    cyc(0, 0, 9'h000, 0, 1, 11'd2047);
    check_eq("f2047", {23'd0, InstOut}, 32'h1FF);
    check_eq("f2047v", {31'd0, InstValid}, 32'd1);
    cyc(0, 0, 9'h000, 0, 0, 11'd0);

    // LoadValid toggling 1,0,1,0,1 with LoadLast on the third valid beat
    cyc(1, 0, 9'h000, 0, 0, 11'd0);
    cyc(0, 1, 9'h0A1, 0, 0, 11'd0);
    cyc(0, 0, 9'h0EE, 1, 0, 11'd0);
    cyc(0, 1, 9'h0A2, 0, 0, 11'd0);
    cyc(0, 0, 9'h0EE, 0, 0, 11'd0);
    cyc(0, 1, 9'h0A3, 1, 0, 11'd0);
    check_eq("tog_len", {20'd0, ProgLen}, 32'd3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 9'h000, 0, 1, 11'(i));
    check_eq("tog_f2", {23'd0, InstOut}, 32'h0A3);

    // Mid-load restart discards the coincident beat
    cyc(1, 0, 9'h000, 0, 0, 11'd0);
    cyc(0, 1, 9'h011, 0, 0, 11'd0);
    cyc(0, 1, 9'h022, 0, 0, 11'd0);
    check_eq("rs_len_hold", {20'd0, ProgLen}, 32'd3);
    cyc(1, 1, 9'h0FF, 0, 0, 11'd0);
    cyc(0, 1, 9'h044, 1, 0, 11'd0);
    check_eq("rs_len", {20'd0, ProgLen}, 32'd1);
    cyc(0, 0, 9'h000, 0, 1, 11'd0);
    check_eq("rs_f0", {23'd0, InstOut}, 32'h044);
    cyc(0, 0, 9'h000, 0, 1, 11'd1);
    check_eq("rs_f1past", {31'd0, PastEnd}, 32'd1);

    // Asynchronous reset during a load
    cyc(1, 0, 9'h000, 0, 1, 11'd0);
    cyc(0, 1, 9'h155, 0, 0, 11'd0);
    #2 Reset = 1'b1;
    #1;
    m_reset();
    check_outs();
    @(posedge Clk); #1;
    Reset = 1'b0;
    check_outs();
    cyc(0, 0, 9'h000, 0, 1, 11'd0);
    check_eq("rst_fetch_blocked", {31'd0, InstValid}, 32'd0);

    // Full-memory boundary on the AW=3 instance
    s_start = 1'b1;
    @(posedge Clk); #1;
    s_start = 1'b0;
    check_eq("s_ready0", {31'd0, s_ready}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1;
      s_data  = 9'h0A0 + 9'(i);
      @(posedge Clk); #1;
      if (i < 7) begin
        check_eq("s_ready_mid", {31'd0, s_ready}, 32'd1);
        check_eq("s_loaded_mid", {31'd0, s_loaded}, 32'd0);
      end else begin
        check_eq("s_ready_full", {31'd0, s_ready}, 32'd0);
        check_eq("s_loaded_full", {31'd0, s_loaded}, 32'd1);
        check_eq("s_len_full", {28'd0, s_len}, 32'd8);
      end
    end
    s_valid = 1'b0;
    s_fetch = 1'b1; s_addr = 3'd0;
    @(posedge Clk); #1;
    check_eq("s_f0", {23'd0, s_inst}, 32'h0A0);
    check_eq("s_f0past", {31'd0, s_past}, 32'd0);
    s_addr = 3'd7;
    @(posedge Clk); #1;
    check_eq("s_f7", {23'd0, s_inst}, 32'h0A7);
    s_fetch = 1'b0;

    // Randomized load/restart/fetch traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rd = 9'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      cyc(($urandom_range(0, 99) < 4), 1'($urandom_range(0, 1)), rd,
          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
